// File: rtl/palette_lut_if.sv
// Pixel stream, palette write and readback signals for palette_lut.
// The master drives pixels and table accesses; the slave is the LUT.
interface palette_lut_if #(
  parameter int IDX_W = 3,
  parameter int RGB_W = 24
);
  logic             pix_valid;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_blank;
  logic [RGB_W-1:0] under_rgb;
  logic             trans_en;
  logic             out_valid;
  logic [RGB_W-1:0] out_rgb;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [RGB_W-1:0] wr_rgb;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [RGB_W-1:0] rd_rgb;

  modport master (
    output pix_valid, pix_idx, pix_blank, under_rgb, trans_en,
    output wr_en, wr_idx, wr_rgb, rd_en, rd_idx,
    input  out_valid, out_rgb, rd_valid, rd_rgb
  );

  modport slave (
    input  pix_valid, pix_idx, pix_blank, under_rgb, trans_en,
    input  wr_en, wr_idx, wr_rgb, rd_en, rd_idx,
    output out_valid, out_rgb, rd_valid, rd_rgb
  );
endinterface

// File: rtl/palette_lut.sv
// Programmable 2-stage colour look-up table for the sprite pixel path.
// Resettable flop table with write-first bypass on both pixel and readback reads.
module palette_lut #(
  parameter int IDX_W     = 3,
  parameter int RGB_W     = 24,
  parameter int TRANS_IDX = 0
) (
  input logic          clk,
  input logic          rst_n,
  palette_lut_if.slave bus
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] TRANS = IDX_W'(TRANS_IDX);

  function automatic logic [RGB_W-1:0] reset_rgb(input int i);
    logic [23:0] c;
    case (i)
      0:       c = 24'hAAAAAA;
      1:       c = 24'h000000;
      2:       c = 24'hFFFFFF;
      3:       c = 24'hFF1551;
      4:       c = 24'hBF8718;
      5:       c = 24'h5EFF00;
      6:       c = 24'h008FFF;
      7:       c = 24'h02006B;
      default: c = 24'h000000;
    endcase
    return RGB_W'(c);
  endfunction

  logic [RGB_W-1:0] pal_q [DEPTH];

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_blank;
  logic [RGB_W-1:0] s1_under;
  logic             s1_trans_en;

  logic             out_valid_q;
  logic [RGB_W-1:0] out_rgb_q;
  logic             rd_valid_q;
  logic [RGB_W-1:0] rd_rgb_q;

  logic [RGB_W-1:0] pix_rgb;
  logic [RGB_W-1:0] rd_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= reset_rgb(i);
    end else if (bus.wr_en) begin
      pal_q[bus.wr_idx] <= bus.wr_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      s1_blank    <= 1'b0;
      s1_under    <= '0;
      s1_trans_en <= 1'b0;
    end else begin
      s1_valid    <= bus.pix_valid;
      s1_idx      <= bus.pix_idx;
      s1_blank    <= bus.pix_blank;
      s1_under    <= bus.under_rgb;
      s1_trans_en <= bus.trans_en;
    end
  end

  // Blank beats transparency beats the (write-first) table lookup.
  always_comb begin
    pix_rgb = pal_q[s1_idx];
    if (s1_blank)
      pix_rgb = '0;
    else if (s1_trans_en && (s1_idx == TRANS))
      pix_rgb = s1_under;
    else if (bus.wr_en && (bus.wr_idx == s1_idx))
      pix_rgb = bus.wr_rgb;
  end

  always_comb begin
    rd_next = pal_q[bus.rd_idx];
    if (bus.wr_en && (bus.wr_idx == bus.rd_idx))
      rd_next = bus.wr_rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_rgb_q    <= '0;
    end else begin
      out_valid_q <= s1_valid;
      out_rgb_q   <= pix_rgb;
      rd_valid_q  <= bus.rd_en;
      if (bus.rd_en) rd_rgb_q <= rd_next;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_rgb   = out_rgb_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_rgb    = rd_rgb_q;
endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: defaults, bypass, transparency, blanking,
// readback and asynchronous reset, with hand-computed expected colours.
module tb_palette_lut;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  palette_lut_if #(.IDX_W(3), .RGB_W(24)) bus ();

  palette_lut #(.IDX_W(3), .RGB_W(24), .TRANS_IDX(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.pix_valid = 1'b0;
    bus.pix_idx   = '0;
    bus.pix_blank = 1'b0;
    bus.under_rgb = '0;
    bus.trans_en  = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_idx    = '0;
    bus.wr_rgb    = '0;
    bus.rd_en     = 1'b0;
    bus.rd_idx    = '0;
  endtask

  task automatic pixel(input logic [2:0] idx, input logic blank, input logic ten,
                       input logic [23:0] under);
    bus.pix_valid = 1'b1;
    bus.pix_idx   = idx;
    bus.pix_blank = blank;
    bus.trans_en  = ten;
    bus.under_rgb = under;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_rgb !== 24'h0) begin
      n_err++;
      $display("FAIL reset_out: got valid=%b rgb=%h, expected valid=0 rgb=000000",
               bus.out_valid, bus.out_rgb);
    end
    n_cmp++;
    if (bus.rd_valid !== 1'b0 || bus.rd_rgb !== 24'h0) begin
      n_err++;
      $display("FAIL reset_rd: got valid=%b rgb=%h, expected valid=0 rgb=000000",
               bus.rd_valid, bus.rd_rgb);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_defaults();
    logic [23:0] exp_def [8];
    int seen;
    exp_def = '{24'hAAAAAA, 24'h000000, 24'hFFFFFF, 24'hFF1551,
                24'hBF8718, 24'h5EFF00, 24'h008FFF, 24'h02006B};
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
      n_cmp++;
      if (bus.out_valid !== ((c >= 2) && (c < 10))) begin
        n_err++;
        $display("FAIL default_valid c=%0d: got %b", c, bus.out_valid);
      end
      if (c >= 2 && c < 10) begin
        n_cmp++;
        if (bus.out_rgb !== exp_def[c-2]) begin
          n_err++;
          $display("FAIL default_rgb idx=%0d: got %h expected %h", c - 2, bus.out_rgb, exp_def[c-2]);
        end
      end
      idle();
      if (c < 8) pixel(3'(c), 1'b0, 1'b0, 24'h0);
    end
    n_cmp++;
    if (seen != 8) begin
      n_err++;
      $display("FAIL default_valid_count: got %0d expected 8", seen);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle(); pixel(3'd3, 1'b0, 1'b0, 24'h0);            // A
    @(negedge clk);
    idle(); pixel(3'd3, 1'b0, 1'b0, 24'h0);            // B
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'hFF1551 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_old: got %h/%b expected FF1551/1", bus.out_rgb, bus.out_valid);
    end
    idle(); pixel(3'd3, 1'b0, 1'b0, 24'h0);            // C
    bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_rgb = 24'h123456;
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'h123456) begin
      n_err++;
      $display("FAIL bypass_same_edge: got %h expected 123456", bus.out_rgb);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'h123456) begin
      n_err++;
      $display("FAIL bypass_after: got %h expected 123456", bus.out_rgb);
    end
  endtask

  task automatic test_trans();
    @(negedge clk);
    idle(); pixel(3'd0, 1'b0, 1'b1, 24'h0A0B0C);
    @(negedge clk);
    idle(); pixel(3'd0, 1'b0, 1'b0, 24'h0A0B0C);
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'h0A0B0C) begin
      n_err++;
      $display("FAIL trans_on: got %h expected 0A0B0C", bus.out_rgb);
    end
    idle(); pixel(3'd2, 1'b0, 1'b1, 24'h0A0B0C);
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'hAAAAAA) begin
      n_err++;
      $display("FAIL trans_off: got %h expected AAAAAA", bus.out_rgb);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'hFFFFFF) begin
      n_err++;
      $display("FAIL trans_other_idx: got %h expected FFFFFF", bus.out_rgb);
    end
  endtask

  task automatic test_blank();
    @(negedge clk);
    idle(); pixel(3'd2, 1'b1, 1'b1, 24'h0A0B0C);
    @(negedge clk);
    idle(); bus.pix_blank = 1'b1; bus.pix_idx = 3'd2;
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'h0 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL blank_valid: got %h/%b expected 000000/1", bus.out_rgb, bus.out_valid);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'h0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL blank_invalid: got %h/%b expected 000000/0", bus.out_rgb, bus.out_valid);
    end
  endtask

  task automatic test_readback();
    @(negedge clk);
    idle(); bus.rd_en = 1'b1; bus.rd_idx = 3'd6;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rgb !== 24'h008FFF || bus.rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rd_plain: got %h/%b expected 008FFF/1", bus.rd_rgb, bus.rd_valid);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rgb !== 24'h008FFF || bus.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_hold: got %h/%b expected 008FFF/0", bus.rd_rgb, bus.rd_valid);
    end
    bus.rd_en = 1'b1; bus.rd_idx = 3'd6;
    bus.wr_en = 1'b1; bus.wr_idx = 3'd6; bus.wr_rgb = 24'h00FF00;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rgb !== 24'h00FF00) begin
      n_err++;
      $display("FAIL rd_bypass: got %h expected 00FF00", bus.rd_rgb);
    end
    // pixel, write and readback all hitting entry 4 on one edge
    idle(); pixel(3'd4, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    idle();
    bus.rd_en = 1'b1; bus.rd_idx = 3'd4;
    bus.wr_en = 1'b1; bus.wr_idx = 3'd4; bus.wr_rgb = 24'h0C0C0C;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_rgb !== 24'h0C0C0C || bus.out_rgb !== 24'h0C0C0C) begin
      n_err++;
      $display("FAIL triple_hit: got rd=%h pix=%h expected 0C0C0C", bus.rd_rgb, bus.out_rgb);
    end
    idle();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle(); pixel(3'd5, 1'b0, 1'b0, 24'h0);
    bus.wr_en = 1'b1; bus.wr_idx = 3'd5; bus.wr_rgb = 24'hFFFFFF;
    bus.rd_en = 1'b1; bus.rd_idx = 3'd5;
    @(negedge clk);
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_rgb !== 24'hFFFFFF || bus.out_valid !== 1'b1 || bus.rd_rgb !== 24'hFFFFFF) begin
      n_err++;
      $display("FAIL pre_reset: got pix=%h/%b rd=%h expected FFFFFF/1 FFFFFF",
               bus.out_rgb, bus.out_valid, bus.rd_rgb);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_rgb !== 24'h0 ||
        bus.rd_valid !== 1'b0 || bus.rd_rgb !== 24'h0) begin
      n_err++;
      $display("FAIL async_clear: got pix=%h/%b rd=%h/%b expected all zero",
               bus.out_rgb, bus.out_valid, bus.rd_rgb, bus.rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pixel(3'd5, 1'b0, 1'b0, 24'h0);
    bus.rd_en = 1'b1; bus.rd_idx = 3'd5;
    @(negedge clk);
    idle();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.rd_rgb !== 24'h5EFF00) begin
      n_err++;
      $display("FAIL post_reset_1: got valid=%b rd=%h expected 0 5EFF00", bus.out_valid, bus.rd_rgb);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_rgb !== 24'h5EFF00) begin
      n_err++;
      $display("FAIL post_reset_2: got %h/%b expected 5EFF00/1", bus.out_rgb, bus.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_bypass();
    test_trans();
    test_blank();
    test_readback();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/palette_lut.md
# palette_lut

Programmable, pipelined colour look-up table that turns sprite pixel indices into RGB for the VGA pixel path. It is the parametrised successor of the fixed 8-colour sprite decoder. Index width, colour width and transparency handling are configurable, and entries can be rewritten at run time. It sits between the sprite pixel fetch and the VGA output register. It runs in the pixel clock domain.

## Interface
Parameters:
- IDX_W, 3, index width in bits; must be ≥ 3; DEPTH = 2**IDX_W entries.
- RGB_W, 24, colour width in bits; must be ≥ 24; the reset colours occupy the low 24 bits and the upper bits are zero.
- TRANS_IDX, 0, index treated as transparent when trans_en = 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1, pixel clock.
  - rst_n, in, 1, asynchronous active-low reset.
- Pixel stream:
  - pix_valid, in, 1, pixel index present this cycle.
  - pix_idx, in, IDX_W, palette index.
  - pix_blank, in, 1, blanking interval; forces black output.
  - under_rgb, in, RGB_W, colour of the layer below; shown for transparent pixels.
  - trans_en, in, 1, enables transparency on TRANS_IDX.
  - out_valid, out, 1, out_rgb is valid.
  - out_rgb, out, RGB_W, resolved colour.
- Write port:
  - wr_en, in, 1, write strobe.
  - wr_idx, in, IDX_W, entry to write.
  - wr_rgb, in, RGB_W, new colour.
- Readback port:
  - rd_en, in, 1, readback request.
  - rd_idx, in, IDX_W, entry to read.
  - rd_valid, out, 1, rd_rgb is valid.
  - rd_rgb, out, RGB_W, entry contents.

## Operation
- Table of DEPTH × RGB_W registers, held in flip-flops so that it can be reset.
- Reset contents:
  - Entries 0..7: AAAAAA, 000000, FFFFFF, FF1551, BF8718, 5EFF00, 008FFF, 02006B.
  - Entries ≥ 8: 0.
- Write: on a clock edge with wr_en = 1, table[wr_idx] ← wr_rgb. There is one write per cycle and no backpressure.
- Stage 1 (S1) registers: pix_valid, pix_idx, pix_blank, under_rgb, and trans_en.
- Stage 2 (S2) registers out_valid ← S1 valid, and out_rgb with the following priority:
  1. S1 blank = 1 → 0.
  2. S1 trans_en = 1 and S1 idx = TRANS_IDX → S1 under_rgb.
  3. wr_en = 1 and wr_idx = S1 idx on the same edge → wr_rgb (write-first bypass).
  4. Otherwise → table[S1 idx].
- Invalid pixels:
  - When S1 valid = 0, out_valid = 0.
  - out_rgb still updates by the same rules; its value is don't-care for the consumer.
- Readback:
  - rd_valid ← rd_en and rd_rgb ← table[rd_idx], one cycle after request.
  - Same write-first bypass when wr_en = 1 and wr_idx = rd_idx on the same edge.
  - When rd_en = 0, rd_rgb holds its previous value.
- No state machine: the block is a free-running 2-stage pipeline with no stall input. The consumer must accept one pixel per clock.

## Timing
- Latency: pixel presented before edge N appears on out_rgb/out_valid after edge N+1, i.e. 2 cycles. Throughput is 1 pixel per cycle.
- Blanking and transparency are aligned with their pixel through the same 2 stages.
- Write visibility:
  - A write on edge N is seen by any pixel whose S2 edge is ≥ N, including the bypass at N.
  - A pixel whose S2 edge is < N sees the old value.
- Readback latency is 1 cycle. Write and readback to the same index on the same edge return the new value.
- Reset (asynchronous, active-low):
  - out_valid = 0, out_rgb = 0, rd_valid = 0, rd_rgb = 0.
  - S1 registers cleared.
  - Table restored to its reset contents.
- Reset asserted mid-stream:
  - Outputs clear immediately, without waiting for a clock edge.
  - First out_valid is 2 edges after the first valid pixel following rst_n rising.
- Index wrap: pix_idx, wr_idx and rd_idx are exactly IDX_W bits wide, so every value addresses an existing entry. No out-of-range handling is needed.
- Simultaneous pixel read, write and readback to one index in one cycle: all three are legal, and both readers see wr_rgb.

## Test plan
- Reset defaults:
  - Stimulus: after reset, stream indices 0..7 with valid = 1, trans_en = 0, blank = 0.
  - Response: out_rgb = AAAAAA, 000000, FFFFFF, FF1551, BF8718, 5EFF00, 008FFF, 02006B, each 2 cycles after its input.
  - out_valid high for exactly 8 cycles.
- Reprogramming and bypass:
  - Write idx 3 ← 123456. On the same edge, S1 holds idx 3 → out_rgb = 123456.
  - A pixel idx 3 whose S2 edge was one cycle earlier → FF1551.
- Transparency:
  - trans_en = 1, TRANS_IDX = 0, under_rgb = 0A0B0C, pix_idx = 0 → out_rgb = 0A0B0C.
  - trans_en = 0 with the same pixel → AAAAAA.
- Blanking priority:
  - pix_blank = 1 with idx 2 and trans_en = 1 → out_rgb = 000000 while out_valid follows pix_valid.
- Readback:
  - rd_en with idx 6 → rd_rgb = 008FFF one cycle later.
  - Same-edge write idx 6 ← 00FF00 together with the read → rd_rgb = 00FF00.
- Asynchronous reset mid-stream:
  - After writing idx 5 ← FFFFFF, drop rst_n between clock edges → outputs clear immediately.
  - Then a pixel with idx 5 → 5EFF00.
